// File: rtl/bmu_pkg.sv
// Shared defaults, derived widths, sweep state type and parity helper for the
// branch metric unit.
package bmu_pkg;

  localparam int DEF_N_MAX  = 6;
  localparam int DEF_K_MAX  = 7;
  localparam int DEF_SOFT_W = 4;
  localparam int DEF_M_MAX  = DEF_K_MAX - 1;
  localparam int DEF_BM_W   = DEF_SOFT_W + 1 + $clog2(DEF_N_MAX);
  localparam int DEF_NP_W   = $clog2(DEF_N_MAX + 1);
  localparam int DEF_ML_W   = $clog2(DEF_K_MAX);

  typedef enum logic [1:0] {
    ST_UNCFG,
    ST_IDLE,
    ST_SWEEP
  } bmu_state_e;

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/bmu_codeword.sv
// Encoder outputs for both branches into state x: window {d, x[M-1:0]} tapped
// by each active generator; inactive generators read as 0.
module bmu_codeword
  import bmu_pkg::*;
#(
  parameter int N_MAX = DEF_N_MAX,
  parameter int K_MAX = DEF_K_MAX
) (
  input  logic [K_MAX-2:0]           state_i,
  input  logic [$clog2(K_MAX)-1:0]   mem_len_i,
  input  logic [N_MAX*K_MAX-1:0]     poly_i,
  input  logic [$clog2(N_MAX+1)-1:0] num_poly_i,
  output logic [N_MAX-1:0]           c_low_o,
  output logic [N_MAX-1:0]           c_high_o
);

  localparam int NP_W = $clog2(N_MAX + 1);

  logic [K_MAX-1:0] w_low;
  logic [K_MAX-1:0] w_high;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    c_low_o  = '0;
    c_high_o = '0;
    w_low    = K_MAX'(state_i) & K_MAX'((1 << mem_len_i) - 1);
    w_high   = w_low | K_MAX'(1 << mem_len_i);
    for (int j = 0; j < N_MAX; j++) begin
      if (NP_W'(j) < num_poly_i) begin
        c_low_o[j]  = parity(32'(w_low  & poly_i[j*K_MAX +: K_MAX]));
        c_high_o[j] = parity(32'(w_high & poly_i[j*K_MAX +: K_MAX]));
      end
    end
  end

endmodule

// File: rtl/bmu_sweep.sv
// Branch metric unit: latches one soft symbol, sweeps every trellis state and
// streams low/high path metrics through a two-stage stallable pipeline.
module bmu_sweep
  import bmu_pkg::*;
#(
  parameter int N_MAX  = DEF_N_MAX,
  parameter int K_MAX  = DEF_K_MAX,
  parameter int SOFT_W = DEF_SOFT_W,
  parameter int BM_W   = SOFT_W + 1 + $clog2(N_MAX)
) (
  input  logic                       clk_i,
  input  logic                       rst_sync_i,
  input  logic                       cfg_load_i,
  input  logic [N_MAX*K_MAX-1:0]     cfg_poly_i,
  input  logic [$clog2(N_MAX+1)-1:0] cfg_num_poly_i,
  input  logic [$clog2(K_MAX)-1:0]   cfg_mem_len_i,
  output logic                       cfg_done_o,
  output logic                       cfg_err_o,
  input  logic                       sym_valid_i,
  output logic                       sym_ready_o,
  input  logic [N_MAX*SOFT_W-1:0]    sym_soft_i,
  input  logic [N_MAX-1:0]           sym_erase_i,
  output logic                       bm_valid_o,
  input  logic                       bm_ready_i,
  output logic [K_MAX-2:0]           bm_state_o,
  output logic signed [BM_W-1:0]     bm_low_o,
  output logic signed [BM_W-1:0]     bm_high_o,
  output logic                       bm_last_o
);

  localparam int M_MAX = K_MAX - 1;
  localparam int NP_W  = $clog2(N_MAX + 1);
  localparam int ML_W  = $clog2(K_MAX);
  localparam int EXT_W = SOFT_W + 1;

  bmu_state_e               state_q;
  logic [N_MAX*K_MAX-1:0]   poly_q;
  logic [NP_W-1:0]          num_poly_q;
  logic [ML_W-1:0]          mem_len_q;
  logic [M_MAX-1:0]         cnt_q;
  logic [N_MAX*SOFT_W-1:0]  soft_q;
  logic [N_MAX-1:0]         erase_q;
  logic                     cfg_err_q;

  logic                     s1_valid_q;
  logic                     s1_last_q;
  logic [M_MAX-1:0]         s1_state_q;
  logic [N_MAX-1:0]         s1_c_low_q;
  logic [N_MAX-1:0]         s1_c_high_q;
  logic [EXT_W-1:0]         s1_op_q [N_MAX];
  logic [EXT_W-1:0]         op_d [N_MAX];

  logic                     bm_valid_q;
  logic                     bm_last_q;
  logic [M_MAX-1:0]         bm_state_q;
  logic [BM_W-1:0]          bm_low_q;
  logic [BM_W-1:0]          bm_high_q;
  logic [BM_W-1:0]          sum_low_d;
  logic [BM_W-1:0]          sum_high_d;
  logic [BM_W-1:0]          ext;

  logic                     en;
  logic                     busy;
  logic                     cfg_ok;
  logic                     sym_ready;
  logic                     accept;
  logic                     issue;
  logic [M_MAX-1:0]         last_cnt;
  logic [N_MAX-1:0]         c_low;
  logic [N_MAX-1:0]         c_high;

  bmu_codeword #(
    .N_MAX (N_MAX),
    .K_MAX (K_MAX)
  ) u_codeword (
    .state_i    (cnt_q),
    .mem_len_i  (mem_len_q),
    .poly_i     (poly_q),
    .num_poly_i (num_poly_q),
    .c_low_o    (c_low),
    .c_high_o   (c_high)
  );

  always_comb begin
    en        = !bm_valid_q || bm_ready_i;
    busy      = (state_q == ST_SWEEP) || s1_valid_q || bm_valid_q;
    cfg_ok    = (cfg_num_poly_i >= NP_W'(2)) && (cfg_num_poly_i <= NP_W'(N_MAX)) &&
                (cfg_mem_len_i >= ML_W'(2)) && (cfg_mem_len_i <= ML_W'(K_MAX - 1));
    // A concurrent config load outranks symbol acceptance, so ready drops with it.
    sym_ready = (state_q == ST_IDLE) && !cfg_load_i;
    accept    = sym_valid_i && sym_ready;
    issue     = (state_q == ST_SWEEP) && en;
    last_cnt  = M_MAX'((1 << mem_len_q) - 1);
    for (int j = 0; j < N_MAX; j++) begin
      op_d[j] = '0;
      if (!erase_q[j] && (NP_W'(j) < num_poly_q)) begin
        op_d[j] = {soft_q[j*SOFT_W+SOFT_W-1], soft_q[j*SOFT_W +: SOFT_W]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_sync_i) begin
      state_q    <= ST_UNCFG;
      poly_q     <= '0;
      num_poly_q <= '0;
      mem_len_q  <= '0;
      cnt_q      <= '0;
      soft_q     <= '0;
      erase_q    <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= cfg_load_i && !(cfg_ok && !busy);
      if (cfg_load_i && cfg_ok && !busy) begin
        poly_q     <= cfg_poly_i;
        num_poly_q <= cfg_num_poly_i;
        mem_len_q  <= cfg_mem_len_i;
        if (state_q == ST_UNCFG) state_q <= ST_IDLE;
      end
      if (accept) begin
        soft_q  <= sym_soft_i;
        erase_q <= sym_erase_i;
        cnt_q   <= '0;
        state_q <= ST_SWEEP;
      end
      if (issue) begin
        cnt_q <= cnt_q + M_MAX'(1);
        if (cnt_q == last_cnt) state_q <= ST_IDLE;
      end
    end
  end

  always_comb begin
    sum_low_d  = '0;
    sum_high_d = '0;
    ext        = '0;
    for (int j = 0; j < N_MAX; j++) begin
      ext        = {{(BM_W-EXT_W){s1_op_q[j][EXT_W-1]}}, s1_op_q[j]};
      sum_low_d  = sum_low_d  + (s1_c_low_q[j]  ? ext : -ext);
      sum_high_d = sum_high_d + (s1_c_high_q[j] ? ext : -ext);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_state_q  <= '0;
      s1_c_low_q  <= '0;
      s1_c_high_q <= '0;
      // NOTE: the operand array is only a few registers, so it is cleared with everything else.
      for (int j = 0; j < N_MAX; j++) s1_op_q[j] <= '0;
      bm_valid_q  <= 1'b0;
      bm_last_q   <= 1'b0;
      bm_state_q  <= '0;
      bm_low_q    <= '0;
      bm_high_q   <= '0;
    end else if (en) begin
      s1_valid_q  <= issue;
      s1_last_q   <= (cnt_q == last_cnt);
      s1_state_q  <= cnt_q;
      s1_c_low_q  <= c_low;
      s1_c_high_q <= c_high;
      for (int j = 0; j < N_MAX; j++) s1_op_q[j] <= op_d[j];
      bm_valid_q  <= s1_valid_q;
      bm_last_q   <= s1_last_q;
      bm_state_q  <= s1_state_q;
      bm_low_q    <= sum_low_d;
      bm_high_q   <= sum_high_d;
    end
  end

  assign cfg_done_o  = (state_q != ST_UNCFG);
  assign cfg_err_o   = cfg_err_q;
  assign sym_ready_o = sym_ready;
  assign bm_valid_o  = bm_valid_q;
  assign bm_state_o  = bm_state_q;
  assign bm_low_o    = bm_low_q;
  assign bm_high_o   = bm_high_q;
  assign bm_last_o   = bm_last_q;

endmodule

// File: tb/tb_bmu_sweep.sv
// Directed bench for bmu_sweep: config handling, metric values, sweep length,
// latency, backpressure and mid-sweep reset.
module tb_bmu_sweep;
  import bmu_pkg::*;

  localparam int N_MAX  = DEF_N_MAX;
  localparam int K_MAX  = DEF_K_MAX;
  localparam int SOFT_W = DEF_SOFT_W;
  localparam int M_MAX  = K_MAX - 1;
  localparam int BM_W   = SOFT_W + 1 + $clog2(N_MAX);
  localparam int NP_W   = $clog2(N_MAX + 1);
  localparam int ML_W   = $clog2(K_MAX);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    cfg_load_i = 1'b0;
  logic [N_MAX*K_MAX-1:0]  cfg_poly_i = '0;
  logic [NP_W-1:0]         cfg_num_poly_i = '0;
  logic [ML_W-1:0]         cfg_mem_len_i = '0;
  logic                    cfg_done_o;
  logic                    cfg_err_o;
  logic                    sym_valid_i = 1'b0;
  logic                    sym_ready_o;
  logic [N_MAX*SOFT_W-1:0] sym_soft_i = '0;
  logic [N_MAX-1:0]        sym_erase_i = '0;
  logic                    bm_valid_o;
  logic                    bm_ready_i = 1'b1;
  logic [M_MAX-1:0]        bm_state_o;
  logic signed [BM_W-1:0]  bm_low_o;
  logic signed [BM_W-1:0]  bm_high_o;
  logic                    bm_last_o;

  int n_checks = 0;
  int n_errors = 0;

  int mdl_m;
  int mdl_n;
  int mdl_g [N_MAX];
  int mdl_s [N_MAX];
  bit mdl_er [N_MAX];

  always #5 clk = ~clk;

  bmu_sweep dut (
    .clk_i          (clk),
    .rst_sync_i     (rst),
    .cfg_load_i     (cfg_load_i),
    .cfg_poly_i     (cfg_poly_i),
    .cfg_num_poly_i (cfg_num_poly_i),
    .cfg_mem_len_i  (cfg_mem_len_i),
    .cfg_done_o     (cfg_done_o),
    .cfg_err_o      (cfg_err_o),
    .sym_valid_i    (sym_valid_i),
    .sym_ready_o    (sym_ready_o),
    .sym_soft_i     (sym_soft_i),
    .sym_erase_i    (sym_erase_i),
    .bm_valid_o     (bm_valid_o),
    .bm_ready_i     (bm_ready_i),
    .bm_state_o     (bm_state_o),
    .bm_low_o       (bm_low_o),
    .bm_high_o      (bm_high_o),
    .bm_last_o      (bm_last_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference metric: walks the window bit by bit with plain integers.
  function automatic int model_bm(input int x, input int d);
    int sum;
    int w;
    int c;
    sum = 0;
    w = x + (d << mdl_m);
    for (int j = 0; j < mdl_n; j++) begin
      if (!mdl_er[j]) begin
        c = 0;
        for (int b = 0; b < K_MAX; b++)
          if ((((w >> b) & 1) == 1) && (((mdl_g[j] >> b) & 1) == 1)) c = c ^ 1;
        sum = sum + ((c == 1) ? mdl_s[j] : -mdl_s[j]);
      end
    end
    return sum;
  endfunction

  task automatic drive_cfg(input int m, input int n, input int g0, input int g1, input int g2);
    cfg_poly_i = '0;
    cfg_poly_i[0*K_MAX +: K_MAX] = K_MAX'(g0);
    cfg_poly_i[1*K_MAX +: K_MAX] = K_MAX'(g1);
    cfg_poly_i[2*K_MAX +: K_MAX] = K_MAX'(g2);
    cfg_num_poly_i = NP_W'(n);
    cfg_mem_len_i  = ML_W'(m);
  endtask

  task automatic load_cfg(input string tag, input int m, input int n,
                          input int g0, input int g1, input int g2, input bit exp_ok);
    drive_cfg(m, n, g0, g1, g2);
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    check({tag, "_err"}, cfg_err_o, !exp_ok);
    check({tag, "_done"}, cfg_done_o, 1);
    if (exp_ok) begin
      mdl_m = m;
      mdl_n = n;
      for (int j = 0; j < N_MAX; j++) mdl_g[j] = 0;
      mdl_g[0] = g0;
      mdl_g[1] = g1;
      mdl_g[2] = g2;
    end
    tick();
    check({tag, "_err_clear"}, cfg_err_o, 0);
  endtask

  task automatic run_sym(input string tag, input int s0, input int s1, input int s2,
                         input logic [N_MAX-1:0] er, input int stall_at, input int stall_len,
                         input int load_at, input bit chk_ready,
                         output logic [BM_W-1:0] first_lo, output logic [BM_W-1:0] first_hi);
    int beats;
    int idx;
    int cyc;
    int budget;
    int extra;
    int lo;
    int hi;
    int load_ph;
    logic [31:0] snap;
    logic [31:0] exp_v;
    beats = 1 << mdl_m;
    idx = 0;
    cyc = 0;
    extra = 0;
    load_ph = 0;
    first_lo = '0;
    first_hi = '0;
    for (int j = 0; j < N_MAX; j++) begin
      mdl_s[j] = 0;
      mdl_er[j] = er[j];
    end
    mdl_s[0] = s0;
    mdl_s[1] = s1;
    mdl_s[2] = s2;
    sym_soft_i = '0;
    sym_soft_i[0*SOFT_W +: SOFT_W] = SOFT_W'(s0);
    sym_soft_i[1*SOFT_W +: SOFT_W] = SOFT_W'(s1);
    sym_soft_i[2*SOFT_W +: SOFT_W] = SOFT_W'(s2);
    sym_erase_i = er;
    sym_valid_i = 1'b1;
    budget = 20;
    while (!sym_ready_o && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_accept_ready"}, sym_ready_o, 1);
    tick();
    sym_valid_i = 1'b0;
    while (idx < beats && cyc < 400) begin
      tick();
      cyc++;
      if (load_ph == 1) begin
        cfg_load_i = 1'b0;
        check({tag, "_busy_load_err"}, cfg_err_o, 1);
        load_ph = 2;
      end else if (load_ph == 2) begin
        check({tag, "_busy_load_err_clear"}, cfg_err_o, 0);
        load_ph = 3;
      end
      if (bm_valid_o) begin
        if (idx == 0) begin
          check({tag, "_first_latency"}, cyc, 2);
          first_lo = bm_low_o;
          first_hi = bm_high_o;
        end
        if (chk_ready) check({tag, "_sym_ready"}, sym_ready_o, idx >= beats - 2);
        if (idx == stall_at) begin
          bm_ready_i = 1'b0;
          snap = {bm_valid_o, bm_last_o, bm_state_o, bm_low_o, bm_high_o};
          for (int k = 0; k < stall_len; k++) begin
            tick();
            cyc++;
            check({tag, "_frozen"}, {bm_valid_o, bm_last_o, bm_state_o, bm_low_o, bm_high_o}, snap);
          end
          bm_ready_i = 1'b1;
        end
        lo = model_bm(idx, 0);
        hi = model_bm(idx, 1);
        exp_v = '0;
        exp_v[22]    = (idx == beats - 1);
        exp_v[21:16] = idx[5:0];
        exp_v[15:8]  = lo[7:0];
        exp_v[7:0]   = hi[7:0];
        check({tag, "_beat"}, {bm_last_o, bm_state_o, bm_low_o, bm_high_o}, exp_v);
        if (idx == load_at) begin
          drive_cfg(2, 3, 7, 5, 3);
          cfg_load_i = 1'b1;
          load_ph = 1;
        end
        idx++;
      end
    end
    cfg_load_i = 1'b0;
    check({tag, "_beat_count"}, idx, beats);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bm_valid_o) extra++;
    end
    check({tag, "_no_extra_beats"}, extra, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [BM_W-1:0] lo0;
    logic [BM_W-1:0] hi0;
    int seen;

    tick();
    tick();
    check("rst_bm_valid", bm_valid_o, 0);
    check("rst_cfg_done", cfg_done_o, 0);
    check("rst_sym_ready", sym_ready_o, 0);
    check("rst_cfg_err", cfg_err_o, 0);
    check("rst_bm_data", {bm_last_o, bm_state_o, bm_low_o, bm_high_o}, 0);
    rst = 1'b0;
    tick();
    check("uncfg_sym_ready", sym_ready_o, 0);

    // K=7 rate-1/2 code: G0=171o, G1=133o
    load_cfg("cfg_k7", 6, 2, 'o171, 'o133, 0, 1'b1);

    run_sym("k7_p3p3", 3, 3, 0, '0, -1, 0, -1, 1'b0, lo0, hi0);
    check("k7_p3p3_x0_low", lo0, 8'hFA);
    check("k7_p3p3_x0_high", hi0, 8'h06);

    run_sym("k7_erase", 3, 3, 0, 6'b000010, 20, 3, -1, 1'b0, lo0, hi0);
    check("k7_erase_x0_low", lo0, 8'hFD);
    check("k7_erase_x0_high", hi0, 8'h03);

    run_sym("k7_m8m8", -8, -8, 0, '0, -1, 0, 5, 1'b0, lo0, hi0);
    check("k7_m8m8_x0_low", lo0, 8'h10);
    check("k7_m8m8_x0_high", hi0, 8'hF0);

    load_cfg("cfg_n7", 6, 7, 'o171, 'o133, 0, 1'b0);
    load_cfg("cfg_m1", 1, 2, 'o3, 'o1, 0, 1'b0);
    run_sym("k7_kept", 5, -2, 0, '0, 7, 1, -1, 1'b0, lo0, hi0);
    check("k7_kept_x0_low", lo0, 8'hFD);

    // M=2 rate-1/3 code: G=7,5,3 (octal)
    load_cfg("cfg_m2", 2, 3, 'o7, 'o5, 'o3, 1'b1);
    run_sym("m2", 3, 2, 1, '0, -1, 0, -1, 1'b1, lo0, hi0);
    check("m2_x0_low", lo0, 8'hFA);
    check("m2_x0_high", hi0, 8'h04);
    check("m2_idle_ready", sym_ready_o, 1);

    // Reset in the middle of a sweep
    sym_soft_i = '0;
    sym_soft_i[0 +: SOFT_W] = SOFT_W'(3);
    sym_valid_i = 1'b1;
    tick();
    sym_valid_i = 1'b0;
    tick();
    tick();
    check("midrst_pre_valid", bm_valid_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_bm_valid", bm_valid_o, 0);
    check("midrst_cfg_done", cfg_done_o, 0);
    check("midrst_sym_ready", sym_ready_o, 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bm_valid_o) seen++;
    end
    check("midrst_no_beats", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
